// File: rtl/processorci_arb_pkg.sv
// rtl/processorci_arb_pkg.sv - shared types and helpers for the OBI-to-Wishbone arbiter
package processorci_arb_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      WR,
      RMW_RD,
      RMW_WR,
      RESP
   } state_e;

   typedef enum logic {
      PORT_INSTR = 1'b0,
      PORT_DATA  = 1'b1
   } port_e;

   localparam logic [31:0] BUS_ERR_DATA = 32'hDEAD_BEEF;

   // Lanes with be set take the new byte, the rest keep the old word's byte.
   function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
      logic [31:0] merged;
      merged = old_word;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/obi_wb_arbiter.sv
// rtl/obi_wb_arbiter.sv - round-robin OBI instr/data to single Wishbone bus with RMW sub-word stores
module obi_wb_arbiter
   import processorci_arb_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  instr_req_i,
   output logic                  instr_gnt_o,
   input  logic [ADDR_WIDTH-1:0] instr_addr_i,
   output logic                  instr_rvalid_o,
   output logic [DATA_WIDTH-1:0] instr_rdata_o,
   input  logic                  data_req_i,
   output logic                  data_gnt_o,
   input  logic                  data_we_i,
   input  logic [3:0]            data_be_i,
   input  logic [ADDR_WIDTH-1:0] data_addr_i,
   input  logic [DATA_WIDTH-1:0] data_wdata_i,
   output logic                  data_rvalid_o,
   output logic [DATA_WIDTH-1:0] data_rdata_o,
   output logic                  wb_cyc_o,
   output logic                  wb_stb_o,
   output logic                  wb_we_o,
   output logic [ADDR_WIDTH-1:0] wb_addr_o,
   output logic [DATA_WIDTH-1:0] wb_data_o,
   input  logic [DATA_WIDTH-1:0] wb_data_i,
   input  logic                  wb_ack_i,
   output logic                  bus_err_o
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);

   state_e                state;
   port_e                 last_port;
   port_e                 owner;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [3:0]            be_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  cyc_q;
   logic                  we_q;
   logic [DATA_WIDTH-1:0] wb_data_q;
   logic                  instr_rvalid_q;
   logic                  data_rvalid_q;
   logic                  bus_err_q;
   logic                  resp_pend;
   logic [CNT_W-1:0]      cnt;
   logic                  instr_win;
   logic                  data_win;

   // Grant is only offered in IDLE; on contention the port not served last wins.
   always_comb begin
      instr_win = 1'b0;
      data_win  = 1'b0;
      if (rst_n && state == IDLE) begin
         if (instr_req_i && data_req_i) begin
            if (last_port == PORT_INSTR) data_win  = 1'b1;
            else                         instr_win = 1'b1;
         end else begin
            instr_win = instr_req_i;
            data_win  = data_req_i;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         last_port      <= PORT_INSTR;
         owner          <= PORT_INSTR;
         addr_q         <= '0;
         be_q           <= '0;
         wdata_q        <= '0;
         rdata_q        <= '0;
         cyc_q          <= 1'b0;
         we_q           <= 1'b0;
         wb_data_q      <= '0;
         instr_rvalid_q <= 1'b0;
         data_rvalid_q  <= 1'b0;
         bus_err_q      <= 1'b0;
         resp_pend      <= 1'b0;
         cnt            <= '0;
      end else begin
         bus_err_q <= 1'b0;
         case (state)
            IDLE: begin
               if (instr_win || data_win) begin
                  owner     <= data_win ? PORT_DATA : PORT_INSTR;
                  last_port <= data_win ? PORT_DATA : PORT_INSTR;
                  cnt       <= '0;
                  rdata_q   <= '0;
                  if (data_win) begin
                     addr_q    <= data_addr_i;
                     be_q      <= data_be_i;
                     wdata_q   <= data_wdata_i;
                     wb_data_q <= data_wdata_i;
                  end else begin
                     addr_q    <= instr_addr_i;
                     be_q      <= '0;
                     wdata_q   <= '0;
                     wb_data_q <= '0;
                  end
                  if (!data_win || !data_we_i) begin
                     state <= RD;
                     cyc_q <= 1'b1;
                     we_q  <= 1'b0;
                  end else if (data_be_i == 4'hF) begin
                     state <= WR;
                     cyc_q <= 1'b1;
                     we_q  <= 1'b1;
                  end else if (data_be_i == 4'h0) begin
                     state     <= RESP;
                     resp_pend <= 1'b1;
                  end else begin
                     state <= RMW_RD;
                     cyc_q <= 1'b1;
                     we_q  <= 1'b0;
                  end
               end
            end
            RD, WR, RMW_RD, RMW_WR: begin
               if (cyc_q && wb_ack_i) begin
                  cyc_q <= 1'b0;
                  cnt   <= '0;
                  case (state)
                     RD: begin
                        rdata_q <= wb_data_i;
                        state   <= RESP;
                        {data_rvalid_q, instr_rvalid_q} <= (owner == PORT_DATA) ? 2'b10 : 2'b01;
                     end
                     RMW_RD: begin
                        wb_data_q <= byte_merge(wb_data_i, wdata_q, be_q);
                        we_q      <= 1'b1;
                        state     <= RMW_WR;
                     end
                     default: begin
                        we_q  <= 1'b0;
                        state <= RESP;
                        {data_rvalid_q, instr_rvalid_q} <= (owner == PORT_DATA) ? 2'b10 : 2'b01;
                     end
                  endcase
               end else if (cyc_q && TIMEOUT_CYCLES > 0 && cnt == CNT_LAST) begin
                  cyc_q     <= 1'b0;
                  we_q      <= 1'b0;
                  bus_err_q <= 1'b1;
                  rdata_q   <= BUS_ERR_DATA;
                  state     <= RESP;
                  {data_rvalid_q, instr_rvalid_q} <= (owner == PORT_DATA) ? 2'b10 : 2'b01;
               end else if (cyc_q) begin
                  cnt <= cnt + 1'b1;
               end else begin
                  // One idle bus cycle between the RMW read and its write-back.
                  cyc_q <= 1'b1;
               end
            end
            RESP: begin
               if (resp_pend) begin
                  resp_pend <= 1'b0;
                  {data_rvalid_q, instr_rvalid_q} <= (owner == PORT_DATA) ? 2'b10 : 2'b01;
               end else begin
                  instr_rvalid_q <= 1'b0;
                  data_rvalid_q  <= 1'b0;
                  state          <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign instr_gnt_o    = instr_win;
   assign data_gnt_o     = data_win;
   assign instr_rvalid_o = instr_rvalid_q;
   assign data_rvalid_o  = data_rvalid_q;
   assign instr_rdata_o  = (owner == PORT_INSTR) ? rdata_q : '0;
   assign data_rdata_o   = (owner == PORT_DATA) ? rdata_q : '0;
   assign wb_cyc_o       = cyc_q;
   assign wb_stb_o       = cyc_q;
   assign wb_we_o        = we_q;
   assign wb_addr_o      = addr_q & WORD_MASK;
   assign wb_data_o      = wb_data_q;
   assign bus_err_o      = bus_err_q;

endmodule

// File: tb/tb_obi_wb_arbiter.sv
// tb/tb_obi_wb_arbiter.sv - randomized self-checking bench for obi_wb_arbiter
module tb_obi_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        instr_req_i = 1'b0;
   logic        instr_gnt_o;
   logic [31:0] instr_addr_i = '0;
   logic        instr_rvalid_o;
   logic [31:0] instr_rdata_o;
   logic        data_req_i = 1'b0;
   logic        data_gnt_o;
   logic        data_we_i = 1'b0;
   logic [3:0]  data_be_i = '0;
   logic [31:0] data_addr_i = '0;
   logic [31:0] data_wdata_i = '0;
   logic        data_rvalid_o;
   logic [31:0] data_rdata_o;
   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic        wb_we_o;
   logic [31:0] wb_addr_o;
   logic [31:0] wb_data_o;
   logic [31:0] wb_data_i = '0;
   logic        wb_ack_i = 1'b0;
   logic        bus_err_o;

   obi_wb_arbiter #(
      .ADDR_WIDTH(32),
      .DATA_WIDTH(32),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .instr_req_i(instr_req_i), .instr_gnt_o(instr_gnt_o), .instr_addr_i(instr_addr_i),
      .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
      .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_we_i(data_we_i),
      .data_be_i(data_be_i), .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
      .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_addr_o(wb_addr_o),
      .wb_data_o(wb_data_o), .wb_data_i(wb_data_i), .wb_ack_i(wb_ack_i), .bus_err_o(bus_err_o)
   );

   initial forever #5 clk = ~clk;

   int n_checks = 0;
   int n_fail = 0;
   int cycle_no = 0;
   logic [31:0] wb_mem [logic [31:0]];
   logic [31:0] ref_mem [logic [31:0]];
   int ack_delay = 1;
   bit no_ack = 1'b0;
   int wr_count = 0;
   logic [31:0] last_wr_addr = '0;
   logic [31:0] last_wr_data = '0;
   int n_irv, n_drv, n_cyc, n_err, n_we;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] wb_rd(input logic [31:0] a);
      return wb_mem.exists(a) ? wb_mem[a] : 32'h0;
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
   endfunction

   function automatic logic [31:0] ref_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] be);
      logic [31:0] mask;
      mask = 32'h0;
      for (int i = 0; i < 4; i++) if (be[i]) mask = mask | (32'hFF << (8 * i));
      return (old_w & ~mask) | (new_w & mask);
   endfunction

   initial forever begin
      @(posedge clk);
      cycle_no++;
   end

   // Wishbone slave: acks ack_delay cycles after it first sees cyc/stb.
   initial begin
      int wait_cnt;
      wait_cnt = 0;
      forever begin
         @(posedge clk);
         #1;
         wb_ack_i = 1'b0;
         if (rst_n && wb_cyc_o && wb_stb_o && !no_ack) begin
            if (wait_cnt >= ack_delay) begin
               wb_ack_i = 1'b1;
               wait_cnt = 0;
               if (wb_we_o) begin
                  wb_mem[wb_addr_o] = wb_data_o;
                  wr_count++;
                  last_wr_addr = wb_addr_o;
                  last_wr_data = wb_data_o;
               end else begin
                  wb_data_i = wb_rd(wb_addr_o);
               end
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (instr_rvalid_o) n_irv++;
      if (data_rvalid_o)  n_drv++;
      if (wb_cyc_o)       n_cyc++;
      if (bus_err_o)      n_err++;
      if (wb_we_o)        n_we++;
   end

   task automatic clear_mon();
      n_irv = 0; n_drv = 0; n_cyc = 0; n_err = 0; n_we = 0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      instr_req_i = 1'b0;
      data_req_i = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic obi_txn(input bit is_data, input bit we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output int lat, output logic [31:0] rdata);
      int t0;
      int waited;
      lat = -1;
      rdata = 32'hx;
      @(negedge clk);
      #1;
      if (is_data) begin
         data_req_i = 1'b1; data_we_i = we; data_be_i = be;
         data_addr_i = addr; data_wdata_i = wdata;
      end else begin
         instr_req_i = 1'b1; instr_addr_i = addr;
      end
      #1;
      waited = 0;
      while (!(is_data ? data_gnt_o : instr_gnt_o) && waited < 50) begin
         @(negedge clk);
         #2;
         waited++;
      end
      if (!(is_data ? data_gnt_o : instr_gnt_o)) begin
         check("gnt_timeout", 32'd0, 32'd1);
         instr_req_i = 1'b0;
         data_req_i = 1'b0;
         return;
      end
      t0 = cycle_no;
      @(posedge clk);
      #1;
      instr_req_i = 1'b0;
      data_req_i = 1'b0;
      waited = 0;
      do begin
         @(negedge clk);
         #1;
         waited++;
      end while (!(is_data ? data_rvalid_o : instr_rvalid_o) && waited < 60);
      if (is_data ? data_rvalid_o : instr_rvalid_o) begin
         lat = cycle_no - t0;
         rdata = is_data ? data_rdata_o : instr_rdata_o;
      end else begin
         check("rvalid_timeout", 32'd0, 32'd1);
      end
   endtask

   task automatic run_one(input string tag, input bit is_data, input bit we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata, input int d);
      logic [31:0] word, old_w, exp_rdata, got_rdata;
      int exp_lat, exp_wr, exp_cyc, got_lat, wr_before;
      word = addr & 32'hFFFF_FFFC;
      old_w = ref_rd(word);
      if (!is_data || !we) begin
         exp_rdata = old_w; exp_lat = d + 2; exp_wr = 0; exp_cyc = d + 1;
      end else if (be == 4'hF) begin
         exp_rdata = 0; exp_lat = d + 2; exp_wr = 1; exp_cyc = d + 1;
         ref_mem[word] = wdata;
      end else if (be == 4'h0) begin
         exp_rdata = 0; exp_lat = 2; exp_wr = 0; exp_cyc = 0;
      end else begin
         exp_rdata = 0; exp_lat = 2 * d + 4; exp_wr = 1; exp_cyc = 2 * (d + 1);
         ref_mem[word] = ref_merge(old_w, wdata, be);
      end
      ack_delay = d;
      clear_mon();
      wr_before = wr_count;
      obi_txn(is_data, we, be, addr, wdata, got_lat, got_rdata);
      check({tag, "_lat"}, 32'(got_lat), 32'(exp_lat));
      check({tag, "_rdata"}, got_rdata, exp_rdata);
      check({tag, "_writes"}, 32'(wr_count - wr_before), 32'(exp_wr));
      check({tag, "_cyc"}, 32'(n_cyc), 32'(exp_cyc));
      check({tag, "_mem"}, wb_rd(word), ref_rd(word));
      check({tag, "_rv_own"}, 32'(is_data ? n_drv : n_irv), 32'd1);
      check({tag, "_rv_other"}, 32'(is_data ? n_irv : n_drv), 32'd0);
      if (exp_wr > 0) check({tag, "_wr_addr"}, last_wr_addr, word);
   endtask

   task automatic run_timeout(input string tag, input bit we, input logic [3:0] be,
                              input logic [31:0] addr, input logic [31:0] wdata);
      logic [31:0] word, got_rdata;
      int got_lat, wr_before;
      word = addr & 32'hFFFF_FFFC;
      no_ack = 1'b1;
      clear_mon();
      wr_before = wr_count;
      obi_txn(1'b1, we, be, addr, wdata, got_lat, got_rdata);
      check({tag, "_lat"}, 32'(got_lat), 32'd9);
      check({tag, "_rdata"}, got_rdata, 32'hDEAD_BEEF);
      check({tag, "_cyc"}, 32'(n_cyc), 32'd8);
      check({tag, "_err"}, 32'(n_err), 32'd1);
      check({tag, "_writes"}, 32'(wr_count - wr_before), 32'd0);
      check({tag, "_mem"}, wb_rd(word), ref_rd(word));
      no_ack = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a, w;
      logic [3:0]  be, ord;
      int g, w_cnt, both;
      bit is_d, we;

      for (int i = 0; i < 4; i++) begin
         w = $urandom;
         wb_mem[32'h2000 + 32'(i * 4)] = w;
         ref_mem[32'h2000 + 32'(i * 4)] = w;
      end
      wb_mem[32'h1000] = 32'h0000_0013;
      ref_mem[32'h1000] = 32'h0000_0013;

      // reset state, with a request present to show grant is held off
      data_req_i = 1'b1;
      #1;
      check("rst_data_gnt", {31'd0, data_gnt_o}, 32'd0);
      check("rst_outputs", {25'd0, instr_gnt_o, instr_rvalid_o, data_rvalid_o, wb_cyc_o,
                             wb_stb_o, wb_we_o, bus_err_o}, 32'd0);
      check("rst_wb_addr", wb_addr_o, 32'd0);
      check("rst_wb_data", wb_data_o, 32'd0);
      do_reset();

      // test 1: instruction fetch
      run_one("t1", 1'b0, 1'b0, 4'h0, 32'h1000, 32'h0, 2);
      check("t1_we_low", 32'(n_we), 32'd0);

      // test 2: round robin with both ports held
      do_reset();
      ack_delay = 1;
      clear_mon();
      @(negedge clk);
      #1;
      instr_req_i = 1'b1; instr_addr_i = 32'h1000;
      data_req_i = 1'b1; data_we_i = 1'b0; data_be_i = 4'hF; data_addr_i = 32'h2004;
      g = 0; w_cnt = 0; both = 0; ord = '0;
      while (g < 4 && w_cnt < 200) begin
         #1;
         if (instr_gnt_o || data_gnt_o) begin
            ord = {ord[2:0], data_gnt_o};
            if (instr_gnt_o && data_gnt_o) both++;
            g++;
            if (g == 4) begin
               @(posedge clk);
               #1;
               instr_req_i = 1'b0;
               data_req_i = 1'b0;
            end
         end
         if (g < 4) begin
            @(negedge clk);
            #1;
            w_cnt++;
         end
      end
      instr_req_i = 1'b0;
      data_req_i = 1'b0;
      repeat (20) @(negedge clk);
      check("t2_grants", 32'(g), 32'd4);
      check("t2_order", {28'd0, ord}, 32'h0000_000A);
      check("t2_exclusive", 32'(both), 32'd0);
      check("t2_instr_rv", 32'(n_irv), 32'd2);
      check("t2_data_rv", 32'(n_drv), 32'd2);

      // test 3: sub-word store through read-modify-write
      wb_mem[32'h2000] = 32'h1122_3344;
      ref_mem[32'h2000] = 32'h1122_3344;
      run_one("t3", 1'b1, 1'b1, 4'b0010, 32'h2003, 32'h0000_AB00, 1);
      check("t3_wr_data", last_wr_data, 32'h1122_AB44);

      // test 4: store with no byte enables
      run_one("t4", 1'b1, 1'b1, 4'h0, 32'h2008, 32'hFFFF_FFFF, 1);

      // test 5: timeouts on a read and on an RMW, then a normal read
      run_timeout("t5_rd", 1'b0, 4'hF, 32'h2004, 32'h0);
      run_timeout("t5_rmw", 1'b1, 4'b0100, 32'h2005, 32'h00CC_0000);
      run_one("t5_after", 1'b1, 1'b0, 4'hF, 32'h2004, 32'h0, 0);

      // test 6: reset while waiting for ack
      no_ack = 1'b1;
      @(negedge clk);
      #1;
      data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'hF;
      data_addr_i = 32'h200C; data_wdata_i = 32'h5555_AAAA;
      @(posedge clk);
      #1;
      data_req_i = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check("t6_busy", {31'd0, wb_cyc_o}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("t6_rst_outputs", {25'd0, instr_gnt_o, instr_rvalid_o, data_rvalid_o, wb_cyc_o,
                                wb_stb_o, wb_we_o, bus_err_o}, 32'd0);
      check("t6_rst_addr", wb_addr_o, 32'd0);
      check("t6_rst_data", wb_data_o, 32'd0);
      clear_mon();
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      no_ack = 1'b0;
      repeat (5) @(negedge clk);
      #1;
      check("t6_no_stale_rv", 32'(n_irv + n_drv), 32'd0);
      check("t6_no_cyc", 32'(n_cyc), 32'd0);
      run_one("t6_after", 1'b1, 1'b0, 4'hF, 32'h200C, 32'h0, 1);

      // randomized traffic against the memory model
      clear_mon();
      for (int k = 0; k < 40; k++) begin
         is_d = 1'($urandom_range(0, 1));
         we = is_d ? 1'($urandom_range(0, 1)) : 1'b0;
         case ($urandom_range(0, 3))
            0:       be = 4'h0;
            1:       be = 4'hF;
            default: be = 4'($urandom_range(1, 14));
         endcase
         a = 32'h2000 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3));
         run_one("rnd", is_d, we, be, a, $urandom, int'($urandom_range(0, 3)));
         check("rnd_no_err", 32'(n_err), 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
